// File: rtl/tb_run_controller.sv
// rtl/tb_run_controller.sv - sequences one testbench run: clear, enable, flush, freeze, report.
module tb_run_controller #(
  parameter int WIDTH        = 32,
  parameter int CLEAR_CYCLES = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_num_vectors,
  input  logic [WIDTH-1:0] i_err_limit,
  input  logic [WIDTH-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_enable,
  output logic             o_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_status,
  output logic [WIDTH-1:0] o_vec_issued
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_COMPL = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  localparam logic [31:0] CLR_LAST = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] FL_LAST  = 32'(FLUSH_CYCLES - 1);

  state_t           state_q;
  logic [WIDTH-1:0] nv_q, el_q, vec_q;
  logic [31:0]      cnt_q;
  logic [1:0]       pend_q, status_q;
  logic             tb_reset_q, enable_q, freeze_q, busy_q, done_q;

  logic             err_hit_d;
  logic             run_last_d;
  logic [1:0]       run_pend_d;

  // Exit priority in RUN: abort beats error limit beats completion.
  always_comb begin
    err_hit_d  = (el_q != '0) && (i_event_ctr >= el_q);
    run_last_d = (vec_q >= nv_q);
    run_pend_d = ST_NONE;
    if (i_abort)         run_pend_d = ST_ABORT;
    else if (err_hit_d)  run_pend_d = ST_ERR;
    else if (run_last_d) run_pend_d = ST_COMPL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      nv_q       <= '0;
      el_q       <= '0;
      vec_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= ST_NONE;
      status_q   <= ST_NONE;
      tb_reset_q <= 1'b0;
      enable_q   <= 1'b0;
      freeze_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q    <= S_CLEAR;
            nv_q       <= i_num_vectors;
            el_q       <= i_err_limit;
            vec_q      <= '0;
            status_q   <= ST_NONE;
            pend_q     <= ST_NONE;
            freeze_q   <= 1'b0;
            tb_reset_q <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= CLR_LAST;
          end
        end
        S_CLEAR: begin
          if (i_abort) begin
            state_q    <= S_FLUSH;
            tb_reset_q <= 1'b0;
            pend_q     <= ST_ABORT;
            cnt_q      <= FL_LAST;
          end else if (cnt_q == '0) begin
            tb_reset_q <= 1'b0;
            if (nv_q == '0) begin
              state_q <= S_FLUSH;
              pend_q  <= ST_COMPL;
              cnt_q   <= FL_LAST;
            end else begin
              // The first enable cycle already counts as vector 1.
              state_q  <= S_RUN;
              enable_q <= 1'b1;
              vec_q    <= WIDTH'(1);
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_RUN: begin
          if (run_pend_d != ST_NONE) begin
            state_q  <= S_FLUSH;
            enable_q <= 1'b0;
            pend_q   <= run_pend_d;
            cnt_q    <= FL_LAST;
          end else if (vec_q != '1) begin
            vec_q <= vec_q + WIDTH'(1);
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            freeze_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            status_q <= pend_q;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tb_reset   = tb_reset_q;
  assign o_enable     = enable_q;
  assign o_freeze     = freeze_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_status     = status_q;
  assign o_vec_issued = vec_q;

endmodule

// File: tb/tb_tb_run_controller.sv
// tb/tb_tb_run_controller.sv - directed and randomized run scenarios against an arithmetic model.
module tb_tb_run_controller;
  localparam int W   = 32;
  localparam int CLR = 4;
  localparam int FL  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, i_abort;
  logic [W-1:0]  i_num_vectors, i_err_limit, i_event_ctr;
  logic          o_tb_reset, o_enable, o_freeze, o_busy, o_done;
  logic [1:0]    o_status;
  logic [W-1:0]  o_vec_issued;

  int checks = 0;
  int errors = 0;

  tb_run_controller #(.WIDTH(W), .CLEAR_CYCLES(CLR), .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_num_vectors(i_num_vectors), .i_err_limit(i_err_limit), .i_event_ctr(i_event_ctr),
    .o_tb_reset(o_tb_reset), .o_enable(o_enable), .o_freeze(o_freeze), .o_busy(o_busy),
    .o_done(o_done), .o_status(o_status), .o_vec_issued(o_vec_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {27'd0, o_tb_reset, o_enable, o_freeze, o_busy, o_done}, 32'd0);
    chk({tag, "_status"}, {30'd0, o_status}, 32'd0);
    chk({tag, "_vec"}, o_vec_issued, 32'd0);
  endtask

  // abort_at/err_at are RUN-cycle indices (1 = first enable cycle), abort_clr a CLEAR-cycle index; 0 = none.
  task automatic run_case(input string tag, input int nv, input int el, input int err_at,
                          input int abort_at, input int abort_clr, input bit mid_start);
    int t_exp, e_exp, st_exp, idx;
    int n_rst, n_en, n_busy, done_c, freeze_c, overlap, st_at_done, vec_at_done;
    e_exp  = 0;
    st_exp = 1;
    if (abort_clr != 0) begin
      t_exp  = abort_clr;
      st_exp = 3;
    end else begin
      t_exp = CLR;
      for (int k = 1; k <= nv; k++) begin
        e_exp = k;
        if (abort_at == k) begin st_exp = 3; break; end
        if (el != 0 && err_at != 0 && k >= err_at) begin st_exp = 2; break; end
        if (k == nv) begin st_exp = 1; break; end
      end
    end

    @(negedge clk);
    i_start       = 1'b1;
    i_abort       = 1'b0;
    i_num_vectors = nv;
    i_err_limit   = el;
    i_event_ctr   = 0;
    @(negedge clk);
    n_rst = 0; n_en = 0; n_busy = 0; done_c = 0; freeze_c = 0; overlap = 0;
    st_at_done = -1; vec_at_done = -1;
    for (int c = 1; c <= 600; c++) begin
      if (c == 1) begin
        chk({tag, "_start_status"}, {30'd0, o_status}, 32'd0);
        chk({tag, "_start_vec"}, o_vec_issued, 32'd0);
        chk({tag, "_start_freeze"}, {31'd0, o_freeze}, 32'd0);
      end
      n_rst  += int'(o_tb_reset);
      n_en   += int'(o_enable);
      n_busy += int'(o_busy);
      if (o_tb_reset && o_enable) overlap++;
      if (o_freeze && freeze_c == 0) freeze_c = c;
      if (o_done) begin
        done_c      = c;
        st_at_done  = int'(o_status);
        vec_at_done = int'(o_vec_issued);
        break;
      end
      idx           = c - CLR;
      i_start       = mid_start && (c == CLR + 2);
      i_num_vectors = $urandom;
      i_err_limit   = $urandom;
      i_abort       = (abort_clr != 0 && c == abort_clr) || (abort_at != 0 && idx == abort_at);
      if (el == 0)                          i_event_ctr = $urandom;
      else if (err_at != 0 && idx >= err_at) i_event_ctr = el + $urandom_range(0, 3);
      else                                   i_event_ctr = el - 1;
      @(negedge clk);
    end
    i_start = 1'b0;
    i_abort = 1'b1;
    chk({tag, "_tb_reset_cycles"}, n_rst, t_exp);
    chk({tag, "_enable_cycles"}, n_en, e_exp);
    chk({tag, "_busy_cycles"}, n_busy, t_exp + e_exp + FL);
    chk({tag, "_done_cycle"}, done_c, t_exp + e_exp + FL + 1);
    chk({tag, "_freeze_cycle"}, freeze_c, t_exp + e_exp + FL + 1);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_status"}, st_at_done, st_exp);
    chk({tag, "_vec"}, vec_at_done, e_exp);
    @(negedge clk);
    i_abort = 1'b0;
    chk({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_status_held"}, {30'd0, o_status}, st_exp);
    chk({tag, "_vec_held"}, o_vec_issued, e_exp);
    chk({tag, "_freeze_held"}, {31'd0, o_freeze}, 32'd1);
  endtask

  initial begin
    int nv, el, ea, aa;
    reset = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_num_vectors = 0; i_err_limit = 0; i_event_ctr = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    run_case("basic10", 10, 0, 0, 0, 0, 1'b0);
    run_case("errlim", 100, 5, 20, 0, 0, 1'b0);
    run_case("abort7", 50, 0, 0, 7, 0, 1'b0);
    run_case("abort_and_err", 30, 4, 8, 8, 0, 1'b0);
    run_case("zero_vec", 0, 0, 0, 0, 0, 1'b0);
    run_case("mid_start", 12, 0, 0, 0, 0, 1'b1);
    run_case("abort_clear", 20, 0, 0, 0, 2, 1'b0);
    run_case("one_vec", 1, 0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      nv = $urandom_range(0, 40);
      el = $urandom_range(0, 5);
      ea = $urandom_range(0, nv + 4);
      aa = $urandom_range(0, nv + 6);
      run_case($sformatf("rand%0d", i), nv, el, ea, aa, 0, 1'(i % 2));
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    i_start = 1'b1; i_num_vectors = 50; i_err_limit = 0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (CLR + 4) @(negedge clk);
    chk("midrst_enable_before", {31'd0, o_enable}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst_idle");

    run_case("after_reset", 6, 0, 0, 0, 0, 1'b0);
    run_case("restart", 9, 3, 4, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tb_run_controller.md
Name: tb_run_controller

Overview:
Sequences one arithmetic test run around the LFSR/driver/monitor/scoreboard testbench. It clears the testbench, enables stimulus for a programmed number of vectors, drains the DUT/monitor pipeline, then freezes the scoreboard. It stops early on an error-count limit or on abort, and reports how the run ended. It sits between the host/control interface and the testbench's reset/enable/freeze inputs.

Parameters:
WIDTH, 32, width of vector count, error limit, event counter input and cycle counter
CLEAR_CYCLES, 4, cycles o_tb_reset is held high at run start (>=1)
FLUSH_CYCLES, 3, drain cycles after enable drops; covers driver delay plus monitor latency (>=1)

Ports:
clk  in  1  single clock (DUT clock domain)
reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle start request; ignored unless in IDLE or DONE
i_abort  in  1  stop request; honoured in CLEAR and RUN
i_num_vectors  in  WIDTH  vectors to issue; sampled on accepted start
i_err_limit  in  WIDTH  stop once the error count reaches this value; 0 = no limit; sampled on start
i_event_ctr  in  WIDTH  scoreboard event (error) count
o_tb_reset  out  1  active-high synchronous reset to the testbench
o_enable  out  1  randomiser enable
o_freeze  out  1  scoreboard freeze
o_busy  out  1  high in CLEAR, RUN and FLUSH
o_done  out  1  one-cycle pulse on entry to DONE
o_status  out  2  0 = none/in progress, 1 = completed, 2 = error limit, 3 = aborted
o_vec_issued  out  WIDTH  count of vectors issued this run

Behaviour:
- Async reset (reset=0): state IDLE; o_tb_reset=0, o_enable=0, o_freeze=0, o_busy=0, o_done=0, o_status=0, o_vec_issued=0. All internal counters are 0. Deassertion is used synchronously.
- States: IDLE, CLEAR, RUN, FLUSH, DONE. All outputs are registered.
- IDLE/DONE + i_start=1 -> CLEAR:
  - Latch i_num_vectors and i_err_limit.
  - Clear o_status, o_vec_issued and o_freeze.
  - Drive o_tb_reset=1 for exactly CLEAR_CYCLES cycles.
- CLEAR -> RUN after CLEAR_CYCLES cycles.
  - If num_vectors==0, go straight to FLUSH with status pending=completed.
  - If i_abort=1, go to FLUSH with pending=aborted.
- RUN:
  - o_enable=1; o_vec_issued increments by 1 every cycle o_enable is high.
  - First RUN cycle: o_vec_issued becomes 1.
  - Exit to FLUSH, with o_enable=0 registered on the same edge, on the earliest of:
    - a) the cycle o_vec_issued would reach num_vectors (the final vector is counted; exactly num_vectors enable cycles) -> pending=completed
    - b) err_limit!=0 and i_event_ctr>=err_limit -> pending=error limit
    - c) i_abort=1 -> pending=aborted
  - Simultaneous exit conditions, priority: abort > error limit > completed.
  - o_vec_issued saturates and never wraps (num_vectors bounds it).
- FLUSH:
  - o_enable=0; wait FLUSH_CYCLES cycles so in-flight vectors are scored.
  - i_abort is ignored in FLUSH.
  - An error limit first reached during FLUSH does not change pending status.
- FLUSH -> DONE:
  - o_freeze=1 (held through DONE), o_busy=0.
  - o_done=1 for exactly one cycle.
  - o_status=pending, held until the next accepted start.
  - o_vec_issued is held.
- DONE + i_start -> CLEAR (re-run). i_abort in IDLE/DONE has no effect.
- i_start while busy is ignored; no queuing.
- o_busy = (state in CLEAR, RUN, FLUSH).
- o_tb_reset and o_enable are never high together.
- Reset mid-run returns to IDLE immediately, with all outputs at their reset values.

Test Plan:
- Reset, then start with num_vectors=10, err_limit=0, no errors:
  - o_tb_reset high for 4 cycles.
  - o_enable high for exactly 10 cycles.
  - 3 flush cycles, then o_done pulse, o_status=1, o_vec_issued=10, o_freeze=1.
- num_vectors=100, err_limit=5, i_event_ctr reaches 5 at RUN cycle 20:
  - o_enable falls on the next edge; o_status=2; o_vec_issued=20.
  - o_freeze rises 3 cycles after o_enable falls.
- i_abort pulsed during RUN cycle 7 with num_vectors=50 -> o_status=3, o_vec_issued=7.
- Abort and error limit asserted together -> o_status=3.
- num_vectors=0 -> CLEAR, then FLUSH, then DONE; o_enable never high; o_status=1; o_vec_issued=0.
- i_start pulsed during RUN -> ignored, run unaffected.
- Async reset asserted mid-RUN -> all outputs 0 within the same cycle.
- Restart from DONE -> o_freeze drops, o_status clears to 0, new run proceeds normally.
